// File: rtl/rvm_constants.sv
// Shared constants for the register-file slice: default sizes and FSM encodings.
// Any block that needs the scrub-state encoding imports this package.
package rvm_constants;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_SCRUB = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rvm_regfile_scoreboard.sv
// Pending-write (busy) tracking for the register file; one flag per architectural register.
// Updates apply in the order flush, clear, set; entering scrub clears everything.
module rvm_regfile_scoreboard
  import rvm_constants::*;
#(
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRPORTS = 2,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ready,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [NRPORTS-1:0]    rs_en,
  input  logic [NRPORTS*AW-1:0] rs_addr,
  input  logic [NRPORTS-1:0]    rs_fwd,
  output logic [NRPORTS-1:0]    rs_busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) busy_d = '0;
    if (ready && wr_en) busy_d[wr_addr] = 1'b0;
    // A reservation in the same cycle as the retiring write is a newer producer.
    if (ready && rsv_en && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    if (clr) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar p = 0; p < NRPORTS; p++) begin : g_port
    assign rs_busy[p] = busy_q[rs_addr[p*AW +: AW]] & rs_en[p] & ~rs_fwd[p];
  end

endmodule

// File: rtl/rvm_regfile.sv
// Integer register file with power-on/requested zero scrub, optional write bypass and busy scoreboard.
// Reads are combinational; the file is unusable (reads 0, writes dropped) until the scrub finishes.
module rvm_regfile
  import rvm_constants::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRPORTS = 2,
  parameter  bit BYPASS  = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    clk_req,
  output logic                    ready,
  input  logic                    clr_req,
  input  logic [NRPORTS-1:0]      rs_en,
  input  logic [NRPORTS*AW-1:0]   rs_addr,
  output logic [NRPORTS*XLEN-1:0] rs_rdata,
  output logic [NRPORTS-1:0]      rs_busy,
  input  logic                    rd_wen,
  input  logic [AW-1:0]           rd_addr,
  input  logic [XLEN-1:0]         rd_wdata,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic                    flush
);

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic              wr_ok;
  logic              scrub_start;
  logic [NRPORTS-1:0] rs_fwd;

  assign ready       = (state_q == RF_IDLE);
  assign wr_ok       = ready && rd_wen && (rd_addr != '0);
  assign scrub_start = ready && clr_req;
  assign clk_req     = rd_wen | rsv_en | flush | clr_req | (state_q != RF_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RF_SCRUB;
      cnt_q   <= CNT_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_SCRUB: begin
        // Hold the counter on the last entry so it never wraps.
        if (cnt_q == CNT_LAST) state_d = RF_IDLE;
        else                   cnt_d   = cnt_q + CNT_FIRST;
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_SCRUB;
          cnt_d   = CNT_FIRST;
        end
      end
      default: begin
        state_d = RF_SCRUB;
        cnt_d   = CNT_FIRST;
      end
    endcase
  end

  // Storage is deliberately unreset; the scrub walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (!ready)     regs_q[cnt_q]   <= '0;
    else if (wr_ok) regs_q[rd_addr] <= rd_wdata;
  end

  for (genvar p = 0; p < NRPORTS; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr      = rs_addr[p*AW +: AW];
    assign rs_fwd[p] = BYPASS && ready && rd_wen && rs_en[p] &&
                       (rd_addr == addr) && (addr != '0);
    assign rs_rdata[p*XLEN +: XLEN] =
        rs_fwd[p]                            ? rd_wdata     :
        (ready && rs_en[p] && (addr != '0))  ? regs_q[addr] : '0;
  end

  rvm_regfile_scoreboard #(
    .NREGS   (NREGS),
    .NRPORTS (NRPORTS)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .ready    (ready),
    .clr      (scrub_start),
    .flush    (flush),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (rd_wen),
    .wr_addr  (rd_addr),
    .rs_en    (rs_en),
    .rs_addr  (rs_addr),
    .rs_fwd   (rs_fwd),
    .rs_busy  (rs_busy)
  );

endmodule

// File: tb/tb_rvm_regfile.sv
// Directed bench: instance A is 32 regs with bypass, instance B is 16 regs without bypass.
module tb_rvm_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        a_clk_req, a_ready, a_clr_req, a_rd_wen, a_rsv_en, a_flush;
  logic [1:0]  a_rs_en, a_rs_busy;
  logic [9:0]  a_rs_addr;
  logic [63:0] a_rs_rdata;
  logic [4:0]  a_rd_addr, a_rsv_addr;
  logic [31:0] a_rd_wdata;

  logic        b_clk_req, b_ready, b_clr_req, b_rd_wen, b_rsv_en, b_flush;
  logic [1:0]  b_rs_en, b_rs_busy;
  logic [7:0]  b_rs_addr;
  logic [63:0] b_rs_rdata;
  logic [3:0]  b_rd_addr, b_rsv_addr;
  logic [31:0] b_rd_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int low;

  rvm_regfile #(.XLEN(32), .NREGS(32), .NRPORTS(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .clk_req(a_clk_req), .ready(a_ready),
    .clr_req(a_clr_req), .rs_en(a_rs_en), .rs_addr(a_rs_addr),
    .rs_rdata(a_rs_rdata), .rs_busy(a_rs_busy), .rd_wen(a_rd_wen),
    .rd_addr(a_rd_addr), .rd_wdata(a_rd_wdata), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr), .flush(a_flush)
  );

  rvm_regfile #(.XLEN(32), .NREGS(16), .NRPORTS(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .clk_req(b_clk_req), .ready(b_ready),
    .clr_req(b_clr_req), .rs_en(b_rs_en), .rs_addr(b_rs_addr),
    .rs_rdata(b_rs_rdata), .rs_busy(b_rs_busy), .rd_wen(b_rd_wen),
    .rd_addr(b_rd_addr), .rd_wdata(b_rd_wdata), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .flush(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    resetn = 1'b1;
    {a_clr_req, a_rd_wen, a_rsv_en, a_flush} = '0;
    {b_clr_req, b_rd_wen, b_rsv_en, b_flush} = '0;
    a_rd_addr = '0; a_rsv_addr = '0; a_rd_wdata = '0;
    b_rd_addr = '0; b_rsv_addr = '0; b_rd_wdata = '0;
    a_rs_en = 2'b11; a_rs_addr = {5'd0, 5'd5};
    b_rs_en = 2'b00; b_rs_addr = '0;
    #2 resetn = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready",   32'(a_ready), 32'd0);
    chk("rst_clk_req", 32'(a_clk_req), 32'd1);
    chk("rst_rdata0",  a_rs_rdata[31:0], 32'd0);
    chk("rst_busy",    32'(a_rs_busy), 32'd0);

    // Scrub length after release
    @(negedge clk);
    resetn = 1'b1;
    low = 0;
    while (!a_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("scrub_len_a", 32'(low), 32'd31);
    a_rs_en = 2'b00;
    #1 chk("clk_req_idle", 32'(a_clk_req), 32'd0);
    a_flush = 1'b1;
    #1 chk("clk_req_flush", 32'(a_clk_req), 32'd1);
    a_flush = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'(i)};
      #1 chk("scrub_zero_a", a_rs_rdata[31:0], 32'd0);
    end

    // Basic write/read and x0
    @(negedge clk);
    a_rd_wen = 1'b1; a_rd_addr = 5'd5; a_rd_wdata = 32'hDEADBEEF;
    a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd5};
    #1 chk("byp_x5", a_rs_rdata[31:0], 32'hDEADBEEF);
    @(negedge clk);
    a_rd_wen = 1'b0; a_rs_en = 2'b11;
    #1 chk("rd_x5", a_rs_rdata[31:0], 32'hDEADBEEF);
    chk("rd_x0", a_rs_rdata[63:32], 32'd0);
    @(negedge clk);
    a_rd_wen = 1'b1; a_rd_addr = 5'd0; a_rd_wdata = 32'h1; a_rs_addr = {5'd5, 5'd0};
    #1 chk("wr_x0_same", a_rs_rdata[31:0], 32'd0);
    @(negedge clk);
    a_rd_wen = 1'b0;
    #1 chk("wr_x0_after", a_rs_rdata[31:0], 32'd0);
    chk("x5_kept", a_rs_rdata[63:32], 32'hDEADBEEF);

    // Bypass with a reserved destination
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7; a_rs_addr = {5'd7, 5'd0};
    #1 chk("rsv_x7_pre", 32'(a_rs_busy[1]), 32'd0);
    @(negedge clk);
    a_rsv_en = 1'b0;
    #1 chk("busy_x7", 32'(a_rs_busy[1]), 32'd1);
    @(negedge clk);
    a_rd_wen = 1'b1; a_rd_addr = 5'd7; a_rd_wdata = 32'h12345678;
    #1 chk("byp_x7_data", a_rs_rdata[63:32], 32'h12345678);
    chk("byp_x7_busy", 32'(a_rs_busy[1]), 32'd0);
    @(negedge clk);
    a_rd_wen = 1'b0;
    #1 chk("x7_after", a_rs_rdata[63:32], 32'h12345678);
    chk("x7_busy_clr", 32'(a_rs_busy[1]), 32'd0);
    a_rs_en = 2'b01;
    #1 chk("en_mask_rd", a_rs_rdata[63:32], 32'd0);

    // Set beats clear; later write clears
    @(negedge clk);
    a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd9};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    @(negedge clk);
    a_rd_wen = 1'b1; a_rd_addr = 5'd9; a_rd_wdata = 32'h99;
    @(negedge clk);
    a_rsv_en = 1'b0; a_rd_wen = 1'b0;
    #1 chk("busy_x9_setwins", 32'(a_rs_busy[0]), 32'd1);
    @(negedge clk);
    a_rd_wen = 1'b1;
    @(negedge clk);
    a_rd_wen = 1'b0;
    #1 chk("busy_x9_clr", 32'(a_rs_busy[0]), 32'd0);

    // Flush with a simultaneous reservation
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd4; a_rs_en = 2'b11; a_rs_addr = {5'd4, 5'd3};
    @(negedge clk);
    a_rsv_en = 1'b0;
    #1 chk("busy_x4", 32'(a_rs_busy[1]), 32'd1);
    @(negedge clk);
    a_flush = 1'b1; a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
    @(negedge clk);
    a_flush = 1'b0; a_rsv_en = 1'b0;
    #1 chk("flush_rsv_x3", 32'(a_rs_busy), 32'b01);
    a_rs_en = 2'b10;
    #1 chk("en_mask_busy", 32'(a_rs_busy[0]), 32'd0);
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0; a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd0};
    @(negedge clk);
    a_rsv_en = 1'b0;
    #1 chk("busy_x0", 32'(a_rs_busy[0]), 32'd0);

    // No-bypass instance returns the old value
    @(negedge clk);
    b_rd_wen = 1'b1; b_rd_addr = 4'd7; b_rd_wdata = 32'h1111;
    b_rs_en = 2'b10; b_rs_addr = {4'd7, 4'd0};
    #1 chk("nobyp_scrubbed", b_rs_rdata[63:32], 32'd0);
    @(negedge clk);
    b_rd_wdata = 32'h12345678;
    #1 chk("nobyp_old", b_rs_rdata[63:32], 32'h1111);
    @(negedge clk);
    b_rd_wen = 1'b0;
    #1 chk("nobyp_new", b_rs_rdata[63:32], 32'h12345678);

    // Load x1..x15, then re-scrub
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      b_rd_wen = 1'b1; b_rd_addr = 4'(i); b_rd_wdata = 32'h100 + 32'(i);
    end
    @(negedge clk);
    b_rd_wen = 1'b0; b_rs_en = 2'b11; b_rs_addr = {4'd15, 4'd1};
    #1 chk("load_x1", b_rs_rdata[31:0], 32'h101);
    chk("load_x15", b_rs_rdata[63:32], 32'h10F);
    @(negedge clk);
    b_clr_req = 1'b1;
    #1 chk("clr_clk_req", 32'(b_clk_req), 32'd1);
    @(negedge clk);
    b_clr_req = 1'b0;
    b_rd_wen = 1'b1; b_rd_addr = 4'd3; b_rd_wdata = 32'hFF;
    #1 chk("scrub_rd_b", b_rs_rdata[31:0], 32'd0);
    low = 0;
    while (!b_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    b_rd_wen = 1'b0;
    chk("scrub_len_b", 32'(low), 32'd15);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      b_rs_en = 2'b01; b_rs_addr = {4'd0, 4'(i)};
      #1 chk("rescrub_zero_b", b_rs_rdata[31:0], 32'd0);
    end

    // Reset in the middle of a scrub restarts it
    @(negedge clk);
    a_clr_req = 1'b1; a_rs_en = 2'b01; a_rs_addr = {5'd0, 5'd3};
    @(negedge clk);
    a_clr_req = 1'b0;
    #1 chk("clr_busy_cleared", 32'(a_rs_busy[0]), 32'd0);
    chk("clr_ready_low", 32'(a_ready), 32'd0);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1 chk("mid_rst_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_clk_req", 32'(a_clk_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    low = 0;
    while (!a_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("restart_len_a", 32'(low), 32'd31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvm_regfile.md
RVM_REGFILE -- requirements
Module: rvm_regfile

Interface
Parameters (name, default, meaning)
REQ-001 SHALL provide XLEN, 32: register data width.
REQ-002 SHALL provide NREGS, 32: register count; legal values are 16 (RV32E) and 32.
REQ-003 SHALL provide NRPORTS, 2: number of read ports; legal range is 1..4.
REQ-004 SHALL provide BYPASS, 1: when 1, write-to-read forwarding is enabled.
REQ-005 SHALL derive AW = clog2(NREGS) internally.

Ports (name, direction, width, meaning)
REQ-006 SHALL provide clk, in, 1: core clock.
REQ-007 SHALL provide resetn, in, 1: reset, asynchronous, active-low.
REQ-008 SHALL provide clk_req, out, 1: block needs a clock this cycle.
REQ-009 SHALL provide ready, out, 1: scrub complete, file usable.
REQ-010 SHALL provide clr_req, in, 1: request a re-scrub of all registers.
REQ-011 SHALL provide rs_en, in, NRPORTS: per-port read enable.
REQ-012 SHALL provide rs_addr, in, NRPORTS*AW: read addresses, with port p at bits [p*AW +: AW].
REQ-013 SHALL provide rs_rdata, out, NRPORTS*XLEN: read data, packed the same way as rs_addr.
REQ-014 SHALL provide rs_busy, out, NRPORTS: per-port pending-write flag.
REQ-015 SHALL provide rd_wen, in, 1; rd_addr, in, AW; rd_wdata, in, XLEN: write port.
REQ-016 SHALL provide rsv_en, in, 1; rsv_addr, in, AW: reserve a destination (set busy).
REQ-017 SHALL provide flush, in, 1: clear all busy bits.

Function
REQ-018 SHALL implement a two-state FSM, SCRUB and IDLE; reset enters SCRUB with scrub counter = 1.
REQ-019 In SCRUB, each cycle SHALL write 0 to reg[cnt] and increment cnt; on cnt == NREGS-1 the write SHALL occur and the FSM SHALL go to IDLE.
REQ-020 The full scrub SHALL take NREGS-1 cycles; ready SHALL be 1 exactly when state == IDLE.
REQ-021 In IDLE, clr_req=1 SHALL enter SCRUB with cnt=1 on the next edge; clr_req is ignored in SCRUB.
REQ-022 Register storage SHALL have no reset; only the FSM, counter and busy bits are reset.
REQ-023 Reads SHALL be combinational: rs_rdata[p] = 0 if !rs_en[p], rs_addr[p]==0, or !ready; otherwise reg[rs_addr[p]].
REQ-024 With BYPASS=1, ready, rd_wen=1 and rd_addr==rs_addr[p]!=0, rs_rdata[p] SHALL equal rd_wdata in the same cycle.
REQ-025 A write SHALL update reg[rd_addr] at the clk edge only when ready and rd_addr!=0; other writes are dropped.
REQ-026 busy[i] SHALL set at the edge when ready, rsv_en=1, rsv_addr==i and i!=0.
REQ-027 busy[i] SHALL clear at the edge when ready, rd_wen=1 and rd_addr==i.
REQ-028 Simultaneous set and clear of the same index: set SHALL win.
REQ-029 flush=1 SHALL clear all busy bits; a simultaneous rsv_en SHALL still set its bit (order: flush, clear, set).
REQ-030 busy[0] SHALL always be 0.
REQ-031 rs_busy[p] SHALL equal busy[rs_addr[p]] & rs_en[p], masked to 0 when a BYPASS forward hits that port.
REQ-032 Entering SCRUB (reset or clr_req) SHALL clear all busy bits.
REQ-033 clk_req SHALL equal rd_wen | rsv_en | flush | clr_req | (state != IDLE).
REQ-034 Width rule: no arithmetic on data; cnt is AW bits and SHALL NOT wrap past NREGS-1.

Reset
REQ-035 While resetn=0: state=SCRUB, cnt=1, busy all 0, ready=0, rs_rdata all 0, rs_busy all 0.
REQ-036 clk_req SHALL be 1 during reset, since state != IDLE.
REQ-037 Reset asserted mid-scrub or mid-operation SHALL restart the scrub from cnt=1.

Structure
REQ-038 FSM state encodings and default XLEN/NREGS SHALL live in the shared constants package (rvm_constants).
REQ-039 Busy tracking SHALL be a sub-module rvm_regfile_scoreboard (params NREGS, NRPORTS).
REQ-040 rvm_regfile_scoreboard SHALL have inputs ready, rsv, wr, flush, clr and port addresses, and output rs_busy.

Verification
REQ-041 Reset release, NREGS=32 -> ready=0 for 31 cycles, then 1; all reads return 0; clk_req falls to rd_wen|rsv_en|flush|clr_req.
REQ-042 Write x5=0xDEADBEEF; next cycle read port0=x5 and port1=x0 -> 0xDEADBEEF and 0; writing x0=0x1 and reading x0 -> 0.
REQ-043 BYPASS=1: rd_wen x7=0x12345678 while port1 reads x7 -> same-cycle rs_rdata[1]=0x12345678 and rs_busy[1]=0; BYPASS=0 -> old value.
REQ-044 rsv x9, then rsv x9 and write x9 in the same cycle -> busy stays 1; a later write x9 clears it; flush with rsv x3 -> only busy[3]=1.
REQ-045 clr_req after loading x1..x15 (NREGS=16) -> ready low 15 cycles; writes during scrub dropped; all reads then 0.
REQ-046 Assert resetn=0 at cnt=10 of a scrub -> restart at cnt=1; ready rises 31 cycles after release.
